tinyalu_p: RTL and testbench

//  Parametrised successor of the tiny ALU: WIDTH-bit operands, 2*WIDTH-bit registered result.

---
 rtl/tinyalu_pkg.sv | 5 +
 rtl/tinyalu_mult_p.sv | 36 +++
 rtl/tinyalu_p.sv | 75 +++++++
 tb/tb_tinyalu_p.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: shared opcode and FSM state types for the parametrised tiny ALU.
package tinyalu_pkg;
  typedef enum logic [2:0] {OP_NOP, OP_ADD, OP_AND, OP_XOR, OP_MUL, OP_SUB, OP_IL6, OP_IL7} op_e;
  typedef enum logic {S_IDLE, S_MULT} state_e;
endpackage

// File: rtl/tinyalu_mult_p.sv
// tinyalu_mult_p: latched-operand multiplier whose down-counter times the multi-cycle multiply.
module tinyalu_mult_p #(
  parameter int WIDTH    = 8,
  parameter int MULT_LAT = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               mult_done
);
  localparam int CW = $clog2(MULT_LAT + 1);
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] ma, mb;
  // Bypass the operand registers on load so a one-cycle multiply sees the live operands.
  assign ma = {{WIDTH{1'b0}}, load ? a : a_q};
  assign mb = {{WIDTH{1'b0}}, load ? b : b_q};
  assign product = ma * mb;
  assign mult_done = cnt == CW'(1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
      cnt <= '0;
    end else if (load) begin
      a_q <= a;
      b_q <= b;
      cnt <= CW'(MULT_LAT - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/tinyalu_p.sv
// tinyalu_p: parametrised tiny ALU with single-cycle ops, multi-cycle multiply and registered result.
module tinyalu_p
  import tinyalu_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MULT_LAT = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         op,
  input  logic               start,
  output logic               done,
  output logic               busy,
  output logic               err,
  output logic [2*WIDTH-1:0] result
);
  state_e state, state_n;
  op_e opc;
  logic done_n, err_n, mult_done;
  logic [2*WIDTH-1:0] result_n, product, za, zb;
  assign opc = op_e'(op);
  assign busy = state == S_MULT;
  assign za = {{WIDTH{1'b0}}, A};
  assign zb = {{WIDTH{1'b0}}, B};
  tinyalu_mult_p #(.WIDTH(WIDTH), .MULT_LAT(MULT_LAT)) u_mult (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (start && state == S_IDLE && opc == OP_MUL),
    .a        (A),
    .b        (B),
    .product  (product),
    .mult_done(mult_done)
  );
  always_comb begin
    state_n  = state;
    done_n   = 1'b0;
    err_n    = 1'b0;
    result_n = result;
    if (state == S_MULT) begin
      if (mult_done) begin
        state_n  = S_IDLE;
        done_n   = 1'b1;
        result_n = product;
      end
    end else if (start) begin
      done_n  = opc != OP_MUL || MULT_LAT == 1;
      err_n   = opc == OP_IL6 || opc == OP_IL7;
      state_n = (opc == OP_MUL && MULT_LAT > 1) ? S_MULT : S_IDLE;
      case (opc)
        OP_NOP:  result_n = result;
        OP_ADD:  result_n = za + zb;
        OP_AND:  result_n = za & zb;
        OP_XOR:  result_n = za ^ zb;
        OP_SUB:  result_n = za - zb;
        OP_MUL:  result_n = MULT_LAT == 1 ? product : result;
        default: result_n = '0;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_n;
      done   <= done_n;
      err    <= err_n;
      result <= result_n;
    end
  end
endmodule

// File: tb/tb_tinyalu_p.sv
// tb_tinyalu_p: vector table, hand sequences and randomized model check of tinyalu_p.
module tb_tinyalu_p;
  localparam int LAT = 3;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic [2:0] op = '0;
  logic start = 1'b0, done, busy, err;
  logic [15:0] result;
  logic [15:0] A16 = '0, B16 = '0;
  logic [2:0] op16 = '0;
  logic start16 = 1'b0, done16, busy16, err16;
  logic [31:0] result16;
  int checks = 0, failures = 0;

  tinyalu_p #(.WIDTH(8), .MULT_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .A(A), .B(B), .op(op), .start(start),
    .done(done), .busy(busy), .err(err), .result(result)
  );
  tinyalu_p #(.WIDTH(16), .MULT_LAT(1)) dut16 (
    .clk(clk), .reset_n(reset_n), .A(A16), .B(B16), .op(op16), .start(start16),
    .done(done16), .busy(busy16), .err(err16), .result(result16)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a, b;
    logic [15:0] res;
    logic        err;
    int          lat;
  } vec_t;
  vec_t vecs[8];

  bit dn[0:399], er[0:399], kp[0:399];
  logic [15:0] rv[0:399];
  logic [15:0] exp_res;
  int busy_until, lat_i, got_lat;
  logic [15:0] got_r;
  logic got_e;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_calc(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    int unsigned x = a, y = b;
    case (o)
      3'd1: return 16'(x + y);
      3'd2: return 16'(x & y);
      3'd3: return 16'(x ^ y);
      3'd4: return 16'(x * y);
      3'd5: return 16'(x - y);
      default: return 16'h0;
    endcase
  endfunction

  task automatic run_vec(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output logic [15:0] r, output logic e);
    op = o; A = a; B = b; start = 1'b1;
    lat = 0; r = '0; e = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      start = 1'b0;
      if (done) begin
        lat = k; r = result; e = err;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{3'd1, 8'hFF, 8'h01, 16'h0100, 1'b0, 1};
    vecs[1] = '{3'd2, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1};
    vecs[2] = '{3'd3, 8'hAA, 8'hFF, 16'h0055, 1'b0, 1};
    vecs[3] = '{3'd5, 8'h00, 8'h01, 16'hFFFF, 1'b0, 1};
    vecs[4] = '{3'd5, 8'h05, 8'h03, 16'h0002, 1'b0, 1};
    vecs[5] = '{3'd4, 8'h0F, 8'h0F, 16'h00E1, 1'b0, LAT};
    vecs[6] = '{3'd7, 8'h12, 8'h34, 16'h0000, 1'b1, 1};
    vecs[7] = '{3'd4, 8'hFF, 8'hFF, 16'hFE01, 1'b0, LAT};
    tick(); tick();
    chk("reset_done", done, 0); chk("reset_busy", busy, 0);
    chk("reset_err", err, 0); chk("reset_result", result, 0);
    reset_n = 1'b1;
    tick();
    foreach (vecs[i]) begin
      run_vec(vecs[i].op, vecs[i].a, vecs[i].b, got_lat, got_r, got_e);
      chk($sformatf("vec%0d_lat", i), got_lat, vecs[i].lat);
      chk($sformatf("vec%0d_result", i), got_r, vecs[i].res);
      chk($sformatf("vec%0d_err", i), got_e, vecs[i].err);
    end
    tick();
    chk("idle_done_low", done, 0);
    // Multiply FF*FF with busy profile, and add during busy ignored, add in done cycle accepted.
    op = 3'd4; A = 8'hFF; B = 8'hFF; start = 1'b1;
    tick();
    chk("mul_busy1", busy, 1); chk("mul_done1", done, 0);
    op = 3'd1; A = 8'h01; B = 8'h01;
    tick();
    start = 1'b0;
    chk("mul_busy2", busy, 1); chk("ign_add_done", done, 0);
    tick();
    chk("mul_done3", done, 1); chk("mul_busy3", busy, 0); chk("mul_result", result, 16'hFE01);
    op = 3'd1; A = 8'h01; B = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    chk("add_after_done", done, 1); chk("add_after_result", result, 16'h0002);
    tick();
    chk("single_done_pulse", done, 0);
    // Back-to-back xor then sub.
    op = 3'd3; A = 8'hF0; B = 8'h0F; start = 1'b1;
    tick();
    chk("b2b_xor_done", done, 1); chk("b2b_xor_result", result, 16'h00FF);
    op = 3'd5; A = 8'h01; B = 8'h02;
    tick();
    start = 1'b0;
    chk("b2b_sub_done", done, 1); chk("b2b_sub_result", result, 16'hFFFF);
    tick();
    chk("b2b_end_done", done, 0);
    // nop keeps result, illegal clears it with err.
    op = 3'd1; A = 8'h12; B = 8'h34; start = 1'b1;
    tick();
    op = 3'd0;
    chk("pre_nop_result", result, 16'h0046);
    tick();
    op = 3'd6;
    chk("nop_done", done, 1); chk("nop_err", err, 0); chk("nop_result", result, 16'h0046);
    tick();
    start = 1'b0;
    chk("ill_done", done, 1); chk("ill_err", err, 1); chk("ill_result", result, 0);
    tick();
    chk("ill_err_pulse", err, 0); chk("ill_done_pulse", done, 0);
    // Reset in the middle of a multiply, after loading a nonzero result.
    op = 3'd1; A = 8'h05; B = 8'h06; start = 1'b1;
    tick();
    op = 3'd4; A = 8'hFF; B = 8'hFF;
    tick();
    start = 1'b0;
    chk("pre_rst_busy", busy, 1); chk("pre_rst_result", result, 16'h000B);
    reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_result", result, 0);
    tick(); tick();
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_no_done", done, 0);
    end
    // WIDTH=16, MULT_LAT=1.
    op16 = 3'd4; A16 = 16'hFFFF; B16 = 16'hFFFF; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    chk("w16_done", done16, 1); chk("w16_busy", busy16, 0); chk("w16_result", result16, 32'hFFFE0001);
    op16 = 3'd1; A16 = 16'hFFFF; B16 = 16'h0001; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    chk("w16_add", result16, 32'h00010000);
    tick();
    chk("w16_done_pulse", done16, 0);
    // Randomized run against the scheduled-completion model.
    exp_res = 16'h0;
    busy_until = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (dn[i] && !kp[i]) exp_res = rv[i];
      chk("rnd_done", done, dn[i]);
      chk("rnd_err", err, er[i]);
      chk("rnd_busy", busy, i < busy_until);
      chk("rnd_result", result, exp_res);
      start = $urandom_range(0, 2) != 0;
      op = 3'($urandom_range(0, 7));
      A = 8'($urandom);
      B = 8'($urandom);
      if (start && i >= busy_until) begin
        lat_i = (op == 3'd4) ? LAT : 1;
        dn[i+lat_i] = 1'b1;
        er[i+lat_i] = op >= 3'd6;
        kp[i+lat_i] = op == 3'd0;
        rv[i+lat_i] = ref_calc(op, A, B);
        if (op == 3'd4) busy_until = i + LAT;
      end
    end
    start = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
